sa_output_collector: RTL
========================

# sa_output_collector

Downstream stage of the fixed-weights GEMM systolic array. Captures every valid output vector the array produces, since the array cannot stall. Tags each vector with its row index within a tile and buffers it in a FIFO. Presents the buffered vectors to the consumer over a valid/ready handshake, and raises a sticky flag if a vector had to be dropped.

## Interface
- SA_SIZE, 3, vector length (matches the array's SA_SIZE)
- WEIGHT_ACTIVATION_SIZE, 8, bit width of each vector element
- DEPTH, 4, FIFO entries; must be a power of two, ≥2
- ROWS_PER_TILE, 4, number of output rows per tile; must be ≥1
- clk  in  1  single clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- sa_outputs  in  [WEIGHT_ACTIVATION_SIZE-1:0] x SA_SIZE  array activation_outputs
- sa_output_valid  in  1  array output_valid
- m_valid  out  1  head entry available
- m_ready  in  1  consumer accepts head this cycle
- m_data  out  [WEIGHT_ACTIVATION_SIZE-1:0] x SA_SIZE  head vector
- m_row_idx  out  $clog2(ROWS_PER_TILE) (min 1)  row index of head within its tile
- m_last  out  1  head is the last row of its tile (m_row_idx == ROWS_PER_TILE-1)
- level  out  $clog2(DEPTH)+1  number of occupied entries
- overflow  out  1  sticky: at least one vector has been dropped

## Operation
- Storage: DEPTH entries. Each entry holds {vector, row_idx}. Write and read pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is tracked by a separate counter with range 0..DEPTH.
- Row counter: 0..ROWS_PER_TILE-1.
  - Advances on every cycle with sa_output_valid=1, whether that vector is stored or dropped.
  - Wraps from ROWS_PER_TILE-1 to 0.
  - Because dropped rows still advance it, the consumer sees a gap in indices after a loss.
  - Reset only by resetn. A deassertion of sa_output_valid does not reset it.
- Push condition: sa_output_valid && (level < DEPTH || pop). A push stores sa_outputs together with the current row counter value.
- Pop condition: m_valid && m_ready.
- Drop condition: sa_output_valid && level == DEPTH && !pop.
  - The vector is discarded.
  - overflow is set on the next edge and held until resetn.
- Simultaneous push and pop:
  - With level == DEPTH: both occur, level unchanged, no drop.
  - With level == 0: no pop is possible (m_valid=0); push only.
- m_valid = (level != 0). m_data, m_row_idx and m_last are driven from the head entry (show-ahead) and are don't-care while m_valid=0.
- Handshake rules:
  - While m_valid=1 and m_ready=0, m_data, m_row_idx and m_last hold stable.
  - m_valid never drops without a pop.
- No arithmetic is performed on the data; vectors pass through bit-exact.
- Reset values (asynchronous, immediate): pointers 0, level 0, row counter 0, overflow 0, m_valid 0. Storage contents are not reset.
- Reset asserted mid-operation empties the FIFO and discards all buffered data. The first sa_output_valid after release gets row_idx 0.

## Timing
- Vector pushed at edge N: visible on m_data with m_valid=1 in cycle N+1 (latency 1).
- Sustained throughput: 1 vector/cycle when m_ready is held at 1; no bubbles are inserted.
- level updates one edge after the push/pop that causes it.
- overflow rises the cycle after the dropping edge.
- FIFO ordering: strictly first-in, first-out.
- The array emits vectors every cycle once valid. The consumer must therefore sustain m_ready=1 on average; DEPTH only absorbs bursts of m_ready=0.

## Test plan
Parameters for all cases: SA_SIZE=2, WEIGHT_ACTIVATION_SIZE=8, DEPTH=4, ROWS_PER_TILE=3.
- Reset state: hold resetn=0 → m_valid=0, level=0, overflow=0. Then drive sa_output_valid=1 with {6,10}, then {9,4}, with m_ready=1 → outputs {6,10} row 0 at cycle+1, then {9,4} row 1; m_last=0 for both.
- Tile wrap: 5 consecutive valid vectors with m_ready=1 → m_row_idx sequence 0,1,2,0,1 and m_last asserted only on the third vector.
- Backpressure and overflow: m_ready=0, 6 valid vectors V0..V5 → level reaches 4. V4 and V5 are dropped and overflow=1 from the cycle after V4. Then m_ready=1 → V0..V3 drain with row_idx 0,1,2,0, then m_valid=0. The next vector pushed carries row_idx 0 (row_idx 1 and 2 were consumed by V4 and V5).
- Full with simultaneous push and pop: fill to 4, then hold sa_output_valid=1 and m_ready=1 for 3 cycles → no drop, overflow stays 0, level stays 4, order preserved.
- Stability: level=2, m_ready=0 for 5 cycles with sa_output_valid=0 → m_data and m_row_idx are unchanged every cycle.
- Mid-operation reset: level=3, pulse resetn low between edges → m_valid and level go to 0 immediately (asynchronously). After release, the first pushed vector has row_idx 0 and overflow=0.

Source files
------------

// File: rtl/sa_output_collector_if.sv
// Bus between the systolic array, the output collector and its consumer.
// Handshake: the collector presents m_valid/m_data/m_row_idx/m_last. A beat
// transfers on a rising edge where m_valid && m_ready. While m_valid=1 and
// m_ready=0 the payload holds stable, and m_valid only falls after a transfer.
// m_ready may depend on m_valid; m_valid never depends on m_ready.
// sa_output_valid has no ready: the array cannot stall.
interface sa_output_collector_if #(
  parameter int SA_SIZE                = 3,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int DEPTH                  = 4,
  parameter int ROWS_PER_TILE          = 4
);
  localparam int RIDX_W = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] sa_outputs;
  logic                                           sa_output_valid;
  logic                                           m_valid;
  logic                                           m_ready;
  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] m_data;
  logic [RIDX_W-1:0]                              m_row_idx;
  logic                                           m_last;
  logic [LVL_W-1:0]                               level;
  logic                                           overflow;

  // Collector side.
  modport master (
    input  sa_outputs, sa_output_valid, m_ready,
    output m_valid, m_data, m_row_idx, m_last, level, overflow
  );

  // Array plus consumer side.
  modport slave (
    output sa_outputs, sa_output_valid, m_ready,
    input  m_valid, m_data, m_row_idx, m_last, level, overflow
  );
endinterface

// File: rtl/sa_output_collector.sv
// Output collector for the systolic array: tags each valid output vector
// with its row index inside the tile, buffers it in a show-ahead FIFO and
// flags (sticky) any vector dropped because the FIFO was full.
module sa_output_collector #(
  parameter int SA_SIZE                = 3,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int DEPTH                  = 4,
  parameter int ROWS_PER_TILE          = 4
) (
  input logic                   clk,
  input logic                   resetn,
  sa_output_collector_if.master bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int RIDX_W = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
  localparam logic [RIDX_W-1:0] ROW_LAST = RIDX_W'(ROWS_PER_TILE - 1);

  typedef struct packed {
    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] vec;
    logic [RIDX_W-1:0]                              row_idx;
  } entry_t;

  // Storage is deliberately not reset; occupancy alone decides validity.
  entry_t mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [LVL_W-1:0]  level_q,    level_d;
  logic [RIDX_W-1:0] row_q,      row_d;
  logic              overflow_q, overflow_d;

  logic push;
  logic pop;
  logic drop;

  // Handshake decode: a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    pop  = (level_q != '0) && bus.m_ready;
    push = bus.sa_output_valid && ((level_q < LVL_FULL) || pop);
    drop = bus.sa_output_valid && !push;
  end

  // Next-state for pointers, occupancy, row counter and overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    row_d      = row_q;
    overflow_d = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Dropped rows still consume an index so the consumer can see the gap.
    if (bus.sa_output_valid) begin
      if (row_q == ROW_LAST) row_d = '0;
      else                   row_d = row_q + RIDX_W'(1);
    end

    if (drop) overflow_d = 1'b1;
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      row_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      row_q      <= row_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry write: vector is tagged with the row index current at capture.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q].vec     <= bus.sa_outputs;
      mem_q[wr_ptr_q].row_idx <= row_q;
    end
  end

  // Show-ahead outputs straight from the head entry and registered state.
  always_comb begin
    bus.m_valid   = (level_q != '0);
    bus.m_data    = mem_q[rd_ptr_q].vec;
    bus.m_row_idx = mem_q[rd_ptr_q].row_idx;
    bus.m_last    = (mem_q[rd_ptr_q].row_idx == ROW_LAST);
    bus.level     = level_q;
    bus.overflow  = overflow_q;
  end
endmodule
